// File: rtl/text_console_if.sv
// Byte-stream input, video RAM port and display-side status of the text console.
interface text_console_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_attr;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;
    logic        busy;

    // Upstream byte source plus the RAM/display side.
    modport master (
        output in_data, in_valid, in_attr, mem_rdata,
        input  in_ready, mem_address, mem_wdata, mem_we, cursor, busy
    );

    // The console itself.
    modport slave (
        input  in_data, in_valid, in_attr, mem_rdata,
        output in_ready, mem_address, mem_wdata, mem_we, cursor, busy
    );
endinterface

// File: rtl/text_console.sv
// Character-stream front end: turns bytes into char/attr writes in the text
// video RAM, tracks the cursor, and performs hardware scroll and clear.
module text_console #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 25,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic          clock,
    input  logic          reset_n,
    text_console_if.slave bus
);

    localparam int unsigned AW           = 12;
    localparam int unsigned CW           = 11;
    localparam int unsigned COL_W        = $clog2(COLS);
    localparam int unsigned ROW_W        = $clog2(ROWS);
    localparam int unsigned ROW_BYTES    = 2 * COLS;
    localparam int unsigned SCREEN_BYTES = 2 * COLS * ROWS;

    localparam logic [AW-1:0]    ROW_STEP   = AW'(ROW_BYTES);
    localparam logic [AW-1:0]    COPY_NEXT  = AW'(ROW_BYTES + 1);
    localparam logic [AW-1:0]    LAST_COPY  = AW'(SCREEN_BYTES - ROW_BYTES - 1);
    localparam logic [AW-1:0]    FILL_START = AW'(SCREEN_BYTES - ROW_BYTES);
    localparam logic [AW-1:0]    LAST_BYTE  = AW'(SCREEN_BYTES - 1);
    localparam logic [AW-1:0]    ONE_ADDR   = AW'(1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] ONE_COL    = COL_W'(1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ONE_ROW    = ROW_W'(1);

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        WCHR,
        WATR,
        SCRD,
        SCWR,
        FILL,
        CLR
    } state_t;

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [7:0]       attr, attr_nxt;
    logic [AW-1:0]    address, address_nxt;
    logic [7:0]       wdata, wdata_nxt;
    logic             we, we_nxt;
    logic             copy, copy_nxt;
    logic             ready, ready_nxt;
    logic             busy_r, busy_nxt;
    logic [CW-1:0]    cursor_r, cursor_nxt;

    // State, position and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            attr     <= '0;
            address  <= '0;
            wdata    <= '0;
            we       <= 1'b0;
            copy     <= 1'b0;
            ready    <= 1'b1;
            busy_r   <= 1'b0;
            cursor_r <= '0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            row      <= row_nxt;
            attr     <= attr_nxt;
            address  <= address_nxt;
            wdata    <= wdata_nxt;
            we       <= we_nxt;
            copy     <= copy_nxt;
            ready    <= ready_nxt;
            busy_r   <= busy_nxt;
            cursor_r <= cursor_nxt;
        end
    end

    // Next state, next position and next values of the registered outputs.
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        attr_nxt    = attr;
        address_nxt = address;
        wdata_nxt   = wdata;
        we_nxt      = 1'b0;
        copy_nxt    = 1'b0;
        ready_nxt   = 1'b0;
        busy_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (bus.in_valid && ready) begin
                    attr_nxt = bus.in_attr;
                    unique case (bus.in_data)
                        CODE_CR: col_nxt = '0;
                        CODE_BS: begin
                            if (col != '0) col_nxt = col - ONE_COL;
                        end
                        CODE_LF: begin
                            if (row == LAST_ROW) begin
                                state_nxt   = SCRD;
                                address_nxt = ROW_STEP;
                                ready_nxt   = 1'b0;
                                busy_nxt    = 1'b1;
                            end else begin
                                row_nxt = row + ONE_ROW;
                            end
                        end
                        CODE_FF: begin
                            state_nxt   = CLR;
                            col_nxt     = '0;
                            row_nxt     = '0;
                            address_nxt = '0;
                            wdata_nxt   = FILL_CHAR;
                            we_nxt      = 1'b1;
                            ready_nxt   = 1'b0;
                            busy_nxt    = 1'b1;
                        end
                        default: begin
                            state_nxt   = WCHR;
                            address_nxt = {cursor_r, 1'b0};
                            wdata_nxt   = bus.in_data;
                            we_nxt      = 1'b1;
                            ready_nxt   = 1'b0;
                        end
                    endcase
                end
            end

            WCHR: begin
                state_nxt   = WATR;
                address_nxt = {cursor_r, 1'b1};
                wdata_nxt   = attr;
                we_nxt      = 1'b1;
            end

            WATR: begin
                if (col == LAST_COL) begin
                    col_nxt = '0;
                    if (row == LAST_ROW) begin
                        state_nxt   = SCRD;
                        address_nxt = ROW_STEP;
                        busy_nxt    = 1'b1;
                    end else begin
                        row_nxt   = row + ONE_ROW;
                        state_nxt = IDLE;
                        ready_nxt = 1'b1;
                    end
                end else begin
                    col_nxt   = col + ONE_COL;
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end
            end

            // Read one row below; the byte arrives while the write address is out.
            SCRD: begin
                state_nxt   = SCWR;
                address_nxt = address - ROW_STEP;
                we_nxt      = 1'b1;
                copy_nxt    = 1'b1;
                busy_nxt    = 1'b1;
            end

            SCWR: begin
                busy_nxt = 1'b1;
                if (address == LAST_COPY) begin
                    state_nxt   = FILL;
                    address_nxt = FILL_START;
                    wdata_nxt   = FILL_CHAR;
                    we_nxt      = 1'b1;
                end else begin
                    state_nxt   = SCRD;
                    address_nxt = address + COPY_NEXT;
                end
            end

            // Fill/clear: even bytes get the fill char, odd bytes the attribute.
            FILL, CLR: begin
                if (address == LAST_BYTE) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else begin
                    address_nxt = address + ONE_ADDR;
                    wdata_nxt   = address[0] ? FILL_CHAR : attr;
                    we_nxt      = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase

        cursor_nxt = CW'(row_nxt) * CW'(COLS) + CW'(col_nxt);
    end

    // Copy phase forwards the RAM read data straight into the write port,
    // since the byte only exists in the cycle its write happens.
    assign bus.mem_wdata   = copy ? bus.mem_rdata : wdata;
    assign bus.mem_address = address;
    assign bus.mem_we      = we;
    assign bus.in_ready    = ready;
    assign bus.busy        = busy_r;
    assign bus.cursor      = cursor_r;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: a video RAM model, a screen model that
// predicts every RAM write and each byte's completion, and a monitor.
module tb_text_console;

    localparam int SCROLL_CYCLES = 7840;
    localparam int CLEAR_CYCLES  = 4000;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [10:0] cursor;
        int          lat;
        int          busy_cycles;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #20 clk = ~clk;

    text_console_if bus();

    text_console #(
        .COLS      (80),
        .ROWS      (25),
        .FILL_CHAR (8'h20)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // Video RAM model: registered read, one cycle latency.
    logic [7:0] ram [0:4095];
    bit         ram_init;

    function automatic logic [7:0] pattern(int i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pattern(i);
            ram_init <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_address] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_address];
    end

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    checks   = 0;
    int    failures = 0;

    bit    acc_evt;
    bit    pending;
    bit    cursor_bad;
    int    lat;
    int    busy_n;
    wr_t   mon_wr;
    done_t mon_done;

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) acc_evt = 1'b1;
    end

    // Monitor: every RAM write and every byte completion is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL mem_write_unexpected addr=%0d data=%h", bus.mem_address, bus.mem_wdata);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    if (bus.mem_address !== mon_wr.addr || bus.mem_wdata !== mon_wr.data) begin
                        failures++;
                        $display("FAIL mem_write got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.mem_address, bus.mem_wdata, mon_wr.addr, mon_wr.data);
                    end
                end
            end
            if (acc_evt) begin
                acc_evt    = 1'b0;
                pending    = 1'b1;
                lat        = 0;
                busy_n     = 0;
                cursor_bad = 1'b0;
            end
            if (pending) begin
                lat++;
                if (bus.busy) begin
                    busy_n++;
                    if (exp_done.size() != 0 && bus.cursor !== exp_done[0].cursor) cursor_bad = 1'b1;
                end
                if (bus.in_ready) begin
                    pending = 1'b0;
                    checks++;
                    if (exp_done.size() == 0) begin
                        failures++;
                        $display("FAIL byte_done_unexpected cursor=%0d", bus.cursor);
                    end else begin
                        mon_done = exp_done.pop_front();
                        if (bus.cursor !== mon_done.cursor || lat != mon_done.lat ||
                            busy_n != mon_done.busy_cycles || cursor_bad) begin
                            failures++;
                            $display("FAIL byte_done got cursor=%0d lat=%0d busy=%0d cursor_moved=%0d expected cursor=%0d lat=%0d busy=%0d",
                                     bus.cursor, lat, busy_n, cursor_bad,
                                     mon_done.cursor, mon_done.lat, mon_done.busy_cycles);
                        end
                    end
                end
            end
        end
    end

    // Screen model.
    logic [7:0] shadow [0:4095];
    int         m_col;
    int         m_row;

    task automatic push_wr(int a, logic [7:0] d);
        wr_t w;
        w.addr    = 12'(a);
        w.data    = d;
        shadow[a] = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_done(int lat_cycles, int busy_cycles);
        done_t x;
        x.cursor      = 11'(m_row * 80 + m_col);
        x.lat         = lat_cycles;
        x.busy_cycles = busy_cycles;
        exp_done.push_back(x);
    endtask

    task automatic push_scroll(logic [7:0] a);
        for (int i = 0; i < 3840; i++) push_wr(i, shadow[i + 160]);
        for (int i = 3840; i < 4000; i++) push_wr(i, (i % 2 == 0) ? 8'h20 : a);
    endtask

    task automatic expect_byte(logic [7:0] d, logic [7:0] a);
        int c;
        case (d)
            8'h0D: begin
                m_col = 0;
                push_done(1, 0);
            end
            8'h08: begin
                if (m_col > 0) m_col--;
                push_done(1, 0);
            end
            8'h0A: begin
                if (m_row == 24) begin
                    push_scroll(a);
                    push_done(1 + SCROLL_CYCLES, SCROLL_CYCLES);
                end else begin
                    m_row++;
                    push_done(1, 0);
                end
            end
            8'h0C: begin
                for (int i = 0; i < 4000; i++) push_wr(i, (i % 2 == 0) ? 8'h20 : a);
                m_col = 0;
                m_row = 0;
                push_done(1 + CLEAR_CYCLES, CLEAR_CYCLES);
            end
            default: begin
                c = m_row * 80 + m_col;
                push_wr(2 * c, d);
                push_wr(2 * c + 1, a);
                if (m_col == 79) begin
                    m_col = 0;
                    if (m_row == 24) begin
                        push_scroll(a);
                        push_done(3 + SCROLL_CYCLES, SCROLL_CYCLES);
                    end else begin
                        m_row++;
                        push_done(3, 0);
                    end
                end else begin
                    m_col++;
                    push_done(3, 0);
                end
            end
        endcase
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(logic [7:0] d, logic [7:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout byte=%h in_ready=%b expected 1", d, bus.in_ready);
        end else begin
            expect_byte(d, a);
            bus.in_data  = d;
            bus.in_attr  = a;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_done.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_done.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = 8'h00;
        bus.in_attr  = 8'h00;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_mem_address", 32'(bus.mem_address), 32'd0);
        check("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("reset_mem_we", 32'(bus.mem_we), 32'd0);
        check("reset_cursor", 32'(bus.cursor), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4096; i++) shadow[i] = pattern(i);
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted in the middle of a clear.
        send(8'h0C, 8'h4F);
        repeat (60) @(negedge clk);
        check("clr_busy_before_abort", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_cursor", 32'(bus.cursor), 32'd0);
        @(posedge clk);
        #1;
        check("abort_next_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_next_busy", 32'(bus.busy), 32'd0);
        exp_wr.delete();
        exp_done.delete();
        pending = 1'b0;
        acc_evt = 1'b0;
        for (int i = 0; i < 4096; i++) shadow[i] = ram[i];
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Printable 'A' at cursor 0.
        send(8'h41, 8'h1F);
        drain();
        check("ram_a_char", 32'(ram[0]), 32'h41);
        check("ram_a_attr", 32'(ram[1]), 32'h1F);
        check("cursor_after_a", 32'(bus.cursor), 32'd1);

        // Reach cursor 85, then CR / BS / LF.
        send(8'h0A, 8'h07);
        for (int i = 0; i < 4; i++) send(8'(8'h61 + i), 8'(8'h10 + i));
        drain();
        check("cursor_85", 32'(bus.cursor), 32'd85);
        send(8'h0D, 8'h07);
        drain();
        check("cursor_cr", 32'(bus.cursor), 32'd80);
        send(8'h08, 8'h07);
        drain();
        check("cursor_bs_col0", 32'(bus.cursor), 32'd80);
        send(8'h0A, 8'h07);
        drain();
        check("cursor_lf", 32'(bus.cursor), 32'd160);

        // Walk to cell 1999 and print 'Z' to force a wrap scroll.
        for (int i = 0; i < 22; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 79; i++) send(8'(8'h30 + (i % 40)), 8'(i));
        drain();
        check("cursor_1999", 32'(bus.cursor), 32'd1999);
        send(8'h5A, 8'h07);
        drain();
        check("cursor_after_wrap", 32'(bus.cursor), 32'd1920);
        check("scroll_row1_char", 32'(ram[2]), 32'h61);
        check("scroll_row1_attr", 32'(ram[3]), 32'h10);
        check("scroll_z_char", 32'(ram[3838]), 32'h5A);
        check("scroll_z_attr", 32'(ram[3839]), 32'h07);
        check("scroll_fill_char", 32'(ram[3998]), 32'h20);
        check("scroll_fill_attr", 32'(ram[3999]), 32'h07);

        // Scroll by LF at row 24 col 10; bytes offered while busy are ignored.
        for (int i = 0; i < 10; i++) send(8'(8'h41 + i), 8'h2C);
        send(8'h0A, 8'h3A);
        repeat (10) @(negedge clk);
        bus.in_data  = 8'h0C;
        bus.in_attr  = 8'h99;
        bus.in_valid = 1'b1;
        repeat (100) @(negedge clk);
        bus.in_valid = 1'b0;
        drain();
        check("cursor_after_lf_scroll", 32'(bus.cursor), 32'd1930);
        check("lf_scroll_fill_attr", 32'(ram[3841]), 32'h3A);

        // Form feed clears the screen.
        send(8'h0C, 8'h1E);
        drain();
        check("cursor_after_ff", 32'(bus.cursor), 32'd0);
        for (int i = 0; i < 4000; i++)
            check($sformatf("ff_ram_%0d", i), 32'(ram[i]), (i % 2 == 0) ? 32'h20 : 32'h1E);
        for (int i = 4000; i < 4096; i++)
            check($sformatf("untouched_ram_%0d", i), 32'(ram[i]), 32'(pattern(i)));
        check("write_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
